// File: rtl/menu_editor.sv
// menu_editor: browse N_OPT configuration options and edit their N_DIG-digit
// BCD values with four active-low push-buttons. SELECT mode scrolls option
// names; EDIT mode steps the cursor digit (with optional decimal carry) and
// auto-repeats while up/dn is held.
module menu_editor #(
  parameter int N_OPT     = 5,
  parameter int IDX_W     = 3,
  parameter int N_DIG     = 6,
  parameter int CHAR_W    = 5,
  parameter int WRAP      = 0,
  parameter int CARRY     = 0,
  parameter int RPT_DELAY = 50,
  parameter int RPT_RATE  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            btn_up,
  input  logic                            btn_dn,
  input  logic                            btn_lf,
  input  logic                            btn_rt,
  input  logic [N_OPT*N_DIG*CHAR_W-1:0]   opt_names,
  output logic [IDX_W-1:0]                conf_selected_index,
  input  logic [N_DIG*4-1:0]              conf_selected_value,
  output logic [N_DIG*4-1:0]              conf_selected_new_value,
  output logic                            conf_selected_set,
  output logic [N_DIG*CHAR_W-1:0]         menu_word,
  output logic [N_DIG-1:0]                blinking
);

  localparam int NW      = N_DIG*CHAR_W;
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CNT_W   = $clog2(RPT_MAX+1) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OPT-1);

  typedef enum logic {SELECT, EDIT} mode_t;

  mode_t            mode;
  logic             await_load;
  logic [IDX_W-1:0] idx;
  logic [N_DIG-1:0] cursor;

  // button bit order: 3 = up, 2 = dn, 1 = lf, 0 = rt
  logic [3:0] btns;
  logic [3:0] hist;
  logic [3:0] ev;
  logic       ev_up, ev_dn, ev_lf, ev_rt;

  logic             rpt_act;
  logic             rpt_dn;
  logic             rpt_first;
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_limit;
  logic             rpt_held;
  logic             rpt_pulse;

  logic             step_req;
  logic             step_dn;
  logic [N_DIG*4-1:0] step_value;
  logic             step_sat;
  logic             chain;
  logic [3:0]       dig;

  logic [NW-1:0]    name_sel;
  logic [NW-1:0]    digit_word;

  assign btns  = {btn_up, btn_dn, btn_lf, btn_rt};
  assign ev_up = ev[3];
  assign ev_dn = ev[2];
  assign ev_lf = ev[1];
  assign ev_rt = ev[0];

  // Registered falling-edge detectors; an event is visible for exactly one tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '1;
      ev   <= '0;
    end else if (ce) begin
      hist <= btns;
      ev   <= hist & ~btns;
    end
  end

  // Name word of the currently browsed option
  always_comb begin
    name_sel = '0;
    for (int unsigned i = 0; i < N_OPT; i++) begin
      if (idx == IDX_W'(i)) name_sel = opt_names[i*NW +: NW];
    end
  end

  // Zero-extended digits of the value being edited
  always_comb begin
    digit_word = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      digit_word[i*CHAR_W +: CHAR_W] = CHAR_W'(conf_selected_new_value[i*4 +: 4]);
    end
  end

  // Auto-repeat pulse generation and step direction (dn wins on ties/holds)
  always_comb begin
    rpt_limit = rpt_first ? CNT_W'(RPT_DELAY) : CNT_W'(RPT_RATE);
    rpt_held  = rpt_dn ? ~btn_dn : ~btn_up;
    rpt_pulse = rpt_act && rpt_held && (rpt_cnt == rpt_limit);
    step_req  = ev_up | ev_dn | rpt_pulse;
    step_dn   = (ev_up | ev_dn) ? ev_dn : (rpt_dn | ~btn_dn);
  end

  // Digit step: chain starts at the cursor digit and only continues while a
  // digit wraps and carrying is enabled; a chain that survives past the MSB
  // means the value is saturated.
  always_comb begin
    step_value = conf_selected_new_value;
    chain      = 1'b0;
    dig        = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      dig = conf_selected_new_value[i*4 +: 4];
      if (dig > 4'd9) dig = 4'd9;
      if (cursor[i]) chain = 1'b1;
      if (chain) begin
        if (step_dn) begin
          if (dig == 4'd0) begin
            step_value[i*4 +: 4] = 4'd9;
          end else begin
            step_value[i*4 +: 4] = dig - 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (dig == 4'd9) begin
            step_value[i*4 +: 4] = 4'd0;
          end else begin
            step_value[i*4 +: 4] = dig + 4'd1;
            chain = 1'b0;
          end
        end
        if (CARRY == 0) chain = 1'b0;
      end
    end
    step_sat = chain;
  end

  // Cursor digit blinks only while editing
  always_comb begin
    blinking = (mode == EDIT) ? cursor : '0;
  end

  // Menu state machine with registered outputs and auto-repeat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode                    <= SELECT;
      await_load              <= 1'b0;
      idx                     <= '0;
      cursor                  <= N_DIG'(1);
      conf_selected_index     <= '0;
      conf_selected_new_value <= '0;
      conf_selected_set       <= 1'b0;
      menu_word               <= '0;
      rpt_act                 <= 1'b0;
      rpt_dn                  <= 1'b0;
      rpt_first               <= 1'b0;
      rpt_cnt                 <= '0;
    end else if (ce) begin
      case (mode)
        SELECT: begin
          menu_word <= name_sel;
          rpt_act   <= 1'b0;
          rpt_cnt   <= '0;
          if (ev_up) begin
            if (idx == '0) idx <= (WRAP != 0) ? LAST : '0;
            else           idx <= idx - 1'b1;
          end else if (ev_dn) begin
            if (idx == LAST) idx <= (WRAP != 0) ? '0 : LAST;
            else             idx <= idx + 1'b1;
          end else if (ev_rt) begin
            conf_selected_index <= idx;
            await_load          <= 1'b1;
            mode                <= EDIT;
          end
        end
        EDIT: begin
          menu_word <= digit_word;
          if (await_load) begin
            conf_selected_new_value <= conf_selected_value;
            conf_selected_set       <= 1'b0;
            await_load              <= 1'b0;
            rpt_act                 <= 1'b0;
            rpt_cnt                 <= '0;
          end else if (ev_rt) begin
            cursor            <= {cursor[N_DIG-2:0], cursor[N_DIG-1]};
            conf_selected_set <= 1'b0;
            rpt_act           <= 1'b0;
            rpt_cnt           <= '0;
          end else if (ev_lf) begin
            mode              <= SELECT;
            conf_selected_set <= 1'b0;
            rpt_act           <= 1'b0;
            rpt_cnt           <= '0;
          end else begin
            if (ev_up | ev_dn) begin
              rpt_act   <= 1'b1;
              rpt_dn    <= ev_dn;
              rpt_first <= 1'b1;
              rpt_cnt   <= CNT_W'(1);
            end else if (rpt_act && !rpt_held) begin
              rpt_act <= 1'b0;
              rpt_cnt <= '0;
            end else if (rpt_pulse) begin
              rpt_first <= 1'b0;
              rpt_cnt   <= CNT_W'(1);
            end else if (rpt_act) begin
              rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
            if (step_req && !step_sat) begin
              conf_selected_new_value <= step_value;
              conf_selected_set       <= 1'b1;
            end else begin
              conf_selected_set <= 1'b0;
            end
          end
        end
        default: mode <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_editor.sv
// Bench for menu_editor: two instances (saturating/per-digit and
// wrapping/carrying) share stimulus and are compared every clock against a
// value-level reference model of the menu behaviour.
module tb_menu_editor;

  localparam int N_OPT = 5, IDX_W = 3, N_DIG = 6, CHAR_W = 5;
  localparam int D = 50, R = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic btn_up = 1'b1, btn_dn = 1'b1, btn_lf = 1'b1, btn_rt = 1'b1;
  logic [N_OPT*N_DIG*CHAR_W-1:0] opt_names = '0;
  logic [23:0] cv = '0;

  logic [2:0]  csi0, csi1;
  logic [23:0] nv0, nv1;
  logic        set0, set1;
  logic [29:0] word0, word1;
  logic [5:0]  blink0, blink1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  menu_editor #(.N_OPT(N_OPT), .IDX_W(IDX_W), .N_DIG(N_DIG), .CHAR_W(CHAR_W),
                .WRAP(0), .CARRY(0), .RPT_DELAY(D), .RPT_RATE(R)) u0 (
    .clk(clk), .rst(rst), .ce(ce), .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_lf(btn_lf), .btn_rt(btn_rt), .opt_names(opt_names),
    .conf_selected_index(csi0), .conf_selected_value(cv),
    .conf_selected_new_value(nv0), .conf_selected_set(set0),
    .menu_word(word0), .blinking(blink0));

  menu_editor #(.N_OPT(N_OPT), .IDX_W(IDX_W), .N_DIG(N_DIG), .CHAR_W(CHAR_W),
                .WRAP(1), .CARRY(1), .RPT_DELAY(D), .RPT_RATE(R)) u1 (
    .clk(clk), .rst(rst), .ce(ce), .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_lf(btn_lf), .btn_rt(btn_rt), .opt_names(opt_names),
    .conf_selected_index(csi1), .conf_selected_value(cv),
    .conf_selected_new_value(nv1), .conf_selected_set(set1),
    .menu_word(word1), .blinking(blink1));

  // reference model state, index 0 -> u0, index 1 -> u1
  int m_mode[2], m_await[2], m_idx[2], m_csi[2], m_cur[2], m_set[2];
  int m_ract[2], m_rdn[2], m_rn[2];
  logic [23:0] m_nv[2];
  logic [29:0] m_word[2];
  logic [3:0]  m_hist, m_ev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] name_of(input int i);
    return opt_names[i*30 +: 30];
  endfunction

  function automatic logic [29:0] show(input logic [23:0] v);
    logic [29:0] w = '0;
    for (int i = 0; i < N_DIG; i++) w[i*5 +: 5] = {1'b0, v[i*4 +: 4]};
    return w;
  endfunction

  function automatic int clampd(input logic [3:0] d);
    return (d > 9) ? 9 : int'(d);
  endfunction

  // value-level step: the digits from k upward form a decimal number
  function automatic logic [23:0] step_val(input logic [23:0] v, input int k,
                                           input bit dn, input bit carry,
                                           output bit ch);
    logic [23:0] r = v;
    int x = 0, m = 1, d;
    ch = 1'b1;
    if (!carry) begin
      d = clampd(v[k*4 +: 4]);
      r[k*4 +: 4] = 4'(dn ? (d + 9) % 10 : (d + 1) % 10);
    end else begin
      for (int i = N_DIG-1; i >= k; i--) begin
        x = x*10 + clampd(v[i*4 +: 4]);
        m = m*10;
      end
      if (dn) begin
        if (x == 0) ch = 1'b0; else x = x - 1;
      end else begin
        if (x == m-1) ch = 1'b0; else x = x + 1;
      end
      if (ch) for (int i = k; i < N_DIG; i++) begin
        r[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_mode[v] = 0; m_await[v] = 0; m_idx[v] = 0; m_csi[v] = 0; m_cur[v] = 0;
      m_set[v] = 0; m_ract[v] = 0; m_rdn[v] = 0; m_rn[v] = 0;
      m_nv[v] = '0; m_word[v] = '0;
    end
    m_hist = 4'hF;
    m_ev   = 4'h0;
  endtask

  task automatic model_step();
    logic [3:0] b, e;
    logic [29:0] wn;
    logic [23:0] nvn;
    bit eu, ed, el, er, do_step, dn, ch;
    b = {btn_up, btn_dn, btn_lf, btn_rt};
    e = m_ev;
    m_ev = m_hist & ~b;
    m_hist = b;
    {eu, ed, el, er} = e;
    for (int v = 0; v < 2; v++) begin
      wn = m_mode[v] ? show(m_nv[v]) : name_of(m_idx[v]);
      if (m_mode[v] == 0) begin
        m_ract[v] = 0;
        if (eu)      m_idx[v] = (m_idx[v] == 0) ? (v ? N_OPT-1 : 0) : m_idx[v] - 1;
        else if (ed) m_idx[v] = (m_idx[v] == N_OPT-1) ? (v ? 0 : N_OPT-1) : m_idx[v] + 1;
        else if (er) begin m_csi[v] = m_idx[v]; m_await[v] = 1; m_mode[v] = 1; end
      end else if (m_await[v]) begin
        m_nv[v] = cv; m_set[v] = 0; m_await[v] = 0; m_ract[v] = 0;
      end else if (er) begin
        m_cur[v] = (m_cur[v] + 1) % N_DIG; m_set[v] = 0; m_ract[v] = 0;
      end else if (el) begin
        m_mode[v] = 0; m_set[v] = 0; m_ract[v] = 0;
      end else begin
        do_step = 0; dn = 0;
        if (eu | ed) begin
          do_step = 1; dn = ed; m_ract[v] = 1; m_rdn[v] = ed; m_rn[v] = 0;
        end else if (m_ract[v]) begin
          if ((m_rdn[v] ? btn_dn : btn_up) == 1'b1) m_ract[v] = 0;
          else begin
            m_rn[v]++;
            if (m_rn[v] == D || (m_rn[v] > D && (m_rn[v] - D) % R == 0)) begin
              do_step = 1; dn = m_rdn[v] || !btn_dn;
            end
          end
        end
        if (do_step) begin
          nvn = step_val(m_nv[v], m_cur[v], dn, v[0], ch);
          if (ch) m_nv[v] = nvn;
          m_set[v] = ch;
        end else m_set[v] = 0;
      end
      m_word[v] = wn;
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".csi0"},   64'(csi0),   64'(m_csi[0]));
    chk({ph, ".nv0"},    64'(nv0),    64'(m_nv[0]));
    chk({ph, ".set0"},   64'(set0),   64'(m_set[0]));
    chk({ph, ".word0"},  64'(word0),  64'(m_word[0]));
    chk({ph, ".blink0"}, 64'(blink0), 64'(m_mode[0] ? (1 << m_cur[0]) : 0));
    chk({ph, ".csi1"},   64'(csi1),   64'(m_csi[1]));
    chk({ph, ".nv1"},    64'(nv1),    64'(m_nv[1]));
    chk({ph, ".set1"},   64'(set1),   64'(m_set[1]));
    chk({ph, ".word1"},  64'(word1),  64'(m_word[1]));
    chk({ph, ".blink1"}, 64'(blink1), 64'(m_mode[1] ? (1 << m_cur[1]) : 0));
  endtask

  // one enabled clock, occasionally preceded by a disabled one
  task automatic tick();
    if ($urandom_range(7) == 0) begin
      ce = 1'b0;
      @(posedge clk); #1;
      compare_all("hold");
    end
    ce = 1'b1;
    @(posedge clk); #1;
    model_step();
    compare_all("tick");
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    {btn_up, btn_dn, btn_lf, btn_rt} = ~mask;
    repeat (hold) tick();
    {btn_up, btn_dn, btn_lf, btn_rt} = 4'hF;
    repeat (gap) tick();
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] r;
    for (int i = 0; i < N_DIG; i++) r[i*4 +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  initial begin
    for (int i = 0; i < N_OPT; i++) opt_names[i*30 +: 30] = 30'($urandom);
    model_reset();
    #3;
    chk("rst.csi0", 64'(csi0), 0);
    chk("rst.set0", 64'(set0), 0);
    chk("rst.word0", 64'(word0), 0);
    chk("rst.blink1", 64'(blink1), 0);
    chk("rst.nv1", 64'(nv1), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SELECT browsing: saturating vs wrapping index
    repeat (3) press(4'b0100, $urandom_range(1, 3), $urandom_range(2, 4));
    tick();
    chk("sel3.word0", 64'(word0), 64'(name_of(3)));
    chk("sel3.word1", 64'(word1), 64'(name_of(3)));
    repeat (2) press(4'b0100, 1, 3);
    tick();
    chk("sat.word0", 64'(word0), 64'(name_of(4)));
    chk("wrap.word1", 64'(word1), 64'(name_of(0)));

    // enter EDIT, value load and display
    cv = 24'h000123;
    press(4'b0001, 1, 4);
    chk("load.nv0", 64'(nv0), 64'h000123);
    chk("load.word1", 64'(word1), 64'(show(24'h000123)));
    chk("load.blink0", 64'(blink0), 64'b000001);

    // digit step with and without carry
    press(4'b0010, 1, 3);
    cv = 24'h000129;
    press(4'b0001, 1, 4);
    press(4'b1000, 1, 3);
    chk("inc.nv0", 64'(nv0), 64'h000120);
    chk("carry.nv1", 64'(nv1), 64'h000130);

    press(4'b0010, 1, 3);
    cv = 24'h999999;
    press(4'b0001, 1, 4);
    press(4'b1000, 1, 3);
    chk("nosat.nv0", 64'(nv0), 64'h999990);
    chk("sat.nv1", 64'(nv1), 64'h999999);

    // auto-repeat: press step + delayed step + two rate steps
    press(4'b0010, 1, 3);
    cv = 24'h000100;
    press(4'b0001, 1, 4);
    press(4'b1000, 81, 4);
    chk("rpt.dig0_0", 64'(nv0[3:0]), 4);
    chk("rpt.nv1", 64'(nv1), 64'h000104);

    // cursor rotation back to LSB, then leave EDIT
    repeat (6) press(4'b0001, 1, 2);
    chk("rot.blink0", 64'(blink0), 64'b000001);
    chk("rot.blink1", 64'(blink1), 64'b000001);
    press(4'b0010, 1, 3);
    chk("lf.blink0", 64'(blink0), 0);

    // simultaneous up+dn decrements
    cv = 24'h000555;
    press(4'b0001, 1, 4);
    press(4'b1100, 1, 3);
    chk("updn.nv0", 64'(nv0), 64'h000554);
    chk("updn.nv1", 64'(nv1), 64'h000554);

    // out-of-range digit treated as 9
    press(4'b0010, 1, 3);
    cv = 24'h00000C;
    press(4'b0001, 1, 4);
    press(4'b1000, 1, 3);
    chk("big.nv0", 64'(nv0), 64'h000000);
    chk("big.nv1", 64'(nv1), 64'h000010);

    // randomized sequence against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(7))
        0: press(4'b1000, $urandom_range(1, 3), $urandom_range(2, 5));
        1: press(4'b0100, $urandom_range(1, 3), $urandom_range(2, 5));
        2: press(4'b0001, 1, $urandom_range(2, 5));
        3: press(4'b0010, 1, $urandom_range(2, 5));
        4: press(4'b1100, $urandom_range(1, 3), $urandom_range(2, 5));
        5: cv = rand_bcd();
        6: press(($urandom_range(1) != 0) ? 4'b1000 : 4'b0100, $urandom_range(40, 75), 3);
        default: press(4'b1100, $urandom_range(45, 70), 3);
      endcase
    end

    // asynchronous reset in the middle of an edit with set high
    press(4'b0010, 1, 3);
    cv = 24'h000321;
    press(4'b0001, 1, 4);
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    chk("pre_rst.set0", 64'(set0), 1);
    chk("pre_rst.set1", 64'(set1), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.set0", 64'(set0), 0);
    chk("arst.set1", 64'(set1), 0);
    chk("arst.blink0", 64'(blink0), 0);
    chk("arst.csi1", 64'(csi1), 0);
    chk("arst.word0", 64'(word0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (4) tick();
    press(4'b0100, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/menu_editor.md
Name: menu_editor

Overview:
- Parametrised successor of the option menu: lets the user browse N_OPT configuration options and edit their N_DIG-digit BCD values with four push-buttons.
- Sits between the debounced button inputs and the configuration store, using the same index/value/new_value/set interface.
- Adds over the previous menu:
  - parametrised option count and digit count;
  - option names supplied as an input table;
  - optional wrap-around of the option index;
  - auto-repeat while up/dn is held;
  - optional decimal carry/borrow across digits;
  - asynchronous reset.

Parameters:
- N_OPT, 5, number of options; index range 0..N_OPT-1.
- IDX_W, 3, width of option index; must satisfy 2^IDX_W >= N_OPT.
- N_DIG, 6, BCD digits per option value (N_DIG >= 2).
- CHAR_W, 5, display character code width (CHAR_W >= 4).
- WRAP, 0, 1 = option index wraps at both ends in SELECT mode; 0 = saturates.
- CARRY, 0, 1 = digit edits carry/borrow into higher digits; 0 = per-digit mod-10.
- RPT_DELAY, 50, ce ticks a held up/dn must last before the first auto-repeat step.
- RPT_RATE, 10, ce ticks between subsequent auto-repeat steps.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; state advances only on edges where ce=1 (a "tick").
- btn_up, btn_dn, btn_lf, btn_rt  in  1 each  buttons, active-low (pressed = 0).
- opt_names  in  N_OPT*N_DIG*CHAR_W  name word per option; option i at slice [i*N_DIG*CHAR_W +: N_DIG*CHAR_W].
- conf_selected_index  out  IDX_W  option index presented to the configuration store.
- conf_selected_value  in  N_DIG*4  current value of the indexed option.
- conf_selected_new_value  out  N_DIG*4  edited value.
- conf_selected_set  out  1  write strobe for the new value.
- menu_word  out  N_DIG*CHAR_W  display word; char 0 = rightmost (LSB).
- blinking  out  N_DIG  one-hot selected digit in EDIT mode, 0 otherwise.

Behaviour:
- Reset values (rst=1, async): all outputs, index and counters are 0, except:
  - cursor = 1 (LSB digit selected);
  - edge-detector history = 1 (released).
- Reset state: SELECT mode, await=0, menu_word=0, blinking=0.
- Press events:
  - Registered negedge detect per button, sampled on ticks.
  - An event is asserted on the tick after the first tick that samples 0 following a 1.
  - An event lasts exactly one tick.
- SELECT mode, each tick:
  - menu_word <= name slice of the current index.
  - Priority: up > dn > rt; lf is ignored.
  - up: index-1. At 0: stays 0 (WRAP=0) or goes to N_OPT-1 (WRAP=1).
  - dn: index+1. At N_OPT-1: stays (WRAP=0) or goes to 0 (WRAP=1).
  - rt: conf_selected_index <= index, await <= 1, mode <= EDIT. Cursor is retained.
- EDIT mode, await=1 tick:
  - new_value <= conf_selected_value, set <= 0, await <= 0.
  - Buttons are ignored on this tick.
- EDIT mode, await=0 tick:
  - Priority: rt > lf > step.
  - rt: cursor rotates one position toward MSB; the MSB wraps to the LSB.
  - lf: mode <= SELECT, set <= 0.
  - step: up/dn event or auto-repeat pulse. If up and dn occur together, dn wins.
  - menu_word: each char <= zero-extended digit of new_value, registered one tick behind new_value.
  - blinking = cursor (combinational from mode and cursor).
- Step arithmetic, on selected digit k:
  - Digit values > 9 are treated as 9.
  - CARRY=0: inc 9→0, dec 0→9; other digits unchanged.
  - CARRY=1, inc: 9→0 and increment digit k+1, recursively.
  - CARRY=1, dec: 0→9 and decrement digit k+1, recursively.
  - CARRY=1 saturation: if digits k..N_DIG-1 are all 9 (inc) or all 0 (dec), value is unchanged and set is not asserted.
- conf_selected_set:
  - Goes 1 on the same tick new_value is updated by a step.
  - Returns to 0 on the next tick without a step.
  - Consecutive step ticks keep it 1.
- Auto-repeat (EDIT, await=0 only):
  - Counter restarts at a press event of up or dn.
  - Counter clears whenever the active raw button reads 1, on lf/rt, or on leaving EDIT.
  - First pulse RPT_DELAY ticks after the press event; then every RPT_RATE ticks while held.
  - Both buttons held: dn governs.
- rst mid-edit: immediate return to reset state; set drops to 0 asynchronously.
- ce=0: all registers hold; conf_selected_set holds its level.

Test Plan:
- Reset then press dn three times in SELECT (N_OPT=5, WRAP=0) → index 3, menu_word = name[3]; press dn twice more → index saturates at 4; with WRAP=1 → index 0.
- Press rt with conf_selected_value=000123 → one await tick, then new_value=000123; menu_word digits 0,0,0,1,2,3; blinking=000001.
- Edit with cursor at digit 0, value 000129: CARRY=0 up → 000120, set pulses 1 tick; CARRY=1 up → 000130; CARRY=1 up on 999999 → unchanged, set stays 0.
- Hold btn_up low for RPT_DELAY+3*RPT_RATE ticks after the press (CARRY=0, digit 0 = 0) → exactly 4 steps total: 1 press + 1 delayed + 2 repeats... measured precisely as 1 + 1 + floor(3*RPT_RATE/RPT_RATE)-1; bench checks digit 0 = 4 when RPT_DELAY=50, RPT_RATE=10, held 80 ticks.
- Press rt six times with N_DIG=6 → cursor returns to 000001; press lf → SELECT, blinking=0; same-tick up+dn in EDIT → decrement.
- Assert rst during EDIT with set=1 → set, blinking, index and mode return to reset values without a clock edge.
